// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the IF and MEM stages: alternating arbitration,
// alignment check, registered downstream command. Optional timeout abort via MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IF_REQ,
  input  logic [63:0] IF_ADDR,
  output logic [63:0] IF_RDATA,
  output logic        IF_RVALID,
  output logic        IF_FAULT,
  output logic        IF_STALL,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [1:0]  MEM_SIZE,
  input  logic [63:0] MEM_ADDR,
  input  logic [63:0] MEM_WDATA,
  output logic [63:0] MEM_RDATA,
  output logic        MEM_RVALID,
  output logic        MEM_FAULT,
  output logic        MEM_STALL,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [1:0]  M_SIZE,
  output logic [63:0] M_ADDR,
  output logic [63:0] M_WDATA,
  input  logic        M_READY,
  input  logic        M_RVALID,
  input  logic [63:0] M_RDATA
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        last_mem_q, last_mem_d;
  logic        owner_mem_q, owner_mem_d;
  logic        cmd_we_q, cmd_we_d;
  logic [1:0]  cmd_size_q, cmd_size_d;
  logic [63:0] cmd_addr_q, cmd_addr_d;
  logic [63:0] cmd_wdata_q, cmd_wdata_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] mem_rdata_q, mem_rdata_d;
  logic        if_fault_q, if_fault_d;
  logic        mem_fault_q, mem_fault_d;

  logic        stale_q;
  logic        tmo_hit;
  logic        grant_mem;
  logic        misaligned;
  logic [1:0]  sel_size;
  logic [63:0] sel_addr;
  logic        resp_wr;
  logic        resp_fault;
  logic [63:0] resp_data;

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    owner_mem_d = owner_mem_q;
    cmd_we_d    = cmd_we_q;
    cmd_size_d  = cmd_size_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    resp_wr     = 1'b0;
    resp_fault  = 1'b0;
    resp_data   = '0;

    // Tie goes to whoever was not granted last
    grant_mem = MEM_REQ && (!IF_REQ || !last_mem_q);
    sel_size  = grant_mem ? MEM_SIZE : 2'b10;
    sel_addr  = grant_mem ? MEM_ADDR : IF_ADDR;

    misaligned = 1'b0;
    case (sel_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = sel_addr[0];
      2'b10:   misaligned = |sel_addr[1:0];
      default: misaligned = |sel_addr[2:0];
    endcase

    case (state_q)
      S_IDLE: begin
        if (!stale_q && (IF_REQ || MEM_REQ)) begin
          owner_mem_d = grant_mem;
          last_mem_d  = grant_mem;
          cmd_we_d    = grant_mem && MEM_WE;
          cmd_size_d  = sel_size;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = grant_mem ? MEM_WDATA : '0;
          if (misaligned) begin
            state_d    = S_RESP;
            resp_wr    = 1'b1;
            resp_fault = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (tmo_hit) begin
          state_d    = S_RESP;
          resp_wr    = 1'b1;
          resp_fault = 1'b1;
        end else if (M_READY) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response wins over a timeout landing in the same cycle
        if (M_RVALID) begin
          state_d   = S_RESP;
          resp_wr   = 1'b1;
          resp_data = cmd_we_q ? '0 : M_RDATA;
        end else if (tmo_hit) begin
          state_d    = S_RESP;
          resp_wr    = 1'b1;
          resp_fault = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if_rdata_d  = if_rdata_q;
    if_fault_d  = if_fault_q;
    mem_rdata_d = mem_rdata_q;
    mem_fault_d = mem_fault_q;
    if (resp_wr && owner_mem_d) begin
      mem_rdata_d = resp_data;
      mem_fault_d = resp_fault;
    end else if (resp_wr) begin
      if_rdata_d = resp_data;
      if_fault_d = resp_fault;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      last_mem_q  <= 1'b0;
      owner_mem_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_size_q  <= 2'b00;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_fault_q  <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      owner_mem_q <= owner_mem_d;
      cmd_we_q    <= cmd_we_d;
      cmd_size_q  <= cmd_size_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_fault_q  <= if_fault_d;
      mem_fault_q <= mem_fault_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          stale_d;

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_WAIT) && (tmo_cnt_q == '0);

  // An abort after the command was accepted leaves one response in flight to swallow
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    stale_d   = stale_q && !M_RVALID;
    if (state_q == S_IDLE && state_d == S_ISSUE) begin
      tmo_cnt_d = TW'(TIMEOUT_CYC - 1);
    end else if ((state_q == S_ISSUE || state_q == S_WAIT) && tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - TW'(1);
    end
    if (tmo_hit && ((state_q == S_ISSUE && M_READY) || (state_q == S_WAIT && !M_RVALID))) begin
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      stale_q   <= stale_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign stale_q = 1'b0;
`endif

  assign IF_RVALID  = (state_q == S_RESP) && !owner_mem_q;
  assign MEM_RVALID = (state_q == S_RESP) && owner_mem_q;
  assign IF_RDATA   = if_rdata_q;
  assign IF_FAULT   = if_fault_q;
  assign MEM_RDATA  = mem_rdata_q;
  assign MEM_FAULT  = mem_fault_q;
  // Gated by reset so every output reads zero while reset is held
  assign IF_STALL   = RESET_N && IF_REQ && !IF_RVALID;
  assign MEM_STALL  = RESET_N && MEM_REQ && !MEM_RVALID;

  assign M_REQ   = (state_q == S_ISSUE);
  assign M_WE    = cmd_we_q;
  assign M_SIZE  = cmd_size_q;
  assign M_ADDR  = cmd_addr_q;
  assign M_WDATA = cmd_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares owner, data, fault and arrival cycle.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IF_REQ = 1'b0;
  logic [63:0] IF_ADDR = '0;
  logic [63:0] IF_RDATA;
  logic        IF_RVALID, IF_FAULT, IF_STALL;
  logic        MEM_REQ = 1'b0;
  logic        MEM_WE = 1'b0;
  logic [1:0]  MEM_SIZE = 2'b00;
  logic [63:0] MEM_ADDR = '0;
  logic [63:0] MEM_WDATA = '0;
  logic [63:0] MEM_RDATA;
  logic        MEM_RVALID, MEM_FAULT, MEM_STALL;
  logic        M_REQ, M_WE;
  logic [1:0]  M_SIZE;
  logic [63:0] M_ADDR, M_WDATA;
  logic        M_READY = 1'b0;
  logic        M_RVALID = 1'b0;
  logic [63:0] M_RDATA = '0;

  mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_RVALID(IF_RVALID),
    .IF_FAULT(IF_FAULT), .IF_STALL(IF_STALL),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_SIZE(MEM_SIZE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
    .MEM_FAULT(MEM_FAULT), .MEM_STALL(MEM_STALL),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_SIZE(M_SIZE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_READY(M_READY), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_mem;
    logic [63:0] data;
    logic        fault;
    int          at;
  } resp_t;

  resp_t exp_q[$];
  resp_t got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_resp(input logic is_mem, input logic [63:0] data, input logic fault,
                             input int at);
    resp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    e.fault  = fault;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (RESET_N && (IF_RVALID || MEM_RVALID)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got if_rvalid=%0b mem_rvalid=%0b expected no response (cycle %0d)",
                 IF_RVALID, MEM_RVALID, cyc);
      end else begin
        got = exp_q.pop_front();
        chk("resp_owner", {62'd0, IF_RVALID, MEM_RVALID}, got.is_mem ? 64'd1 : 64'd2);
        chk("resp_data", got.is_mem ? MEM_RDATA : IF_RDATA, got.data);
        chk("resp_fault", {63'd0, got.is_mem ? MEM_FAULT : IF_FAULT}, {63'd0, got.fault});
        chk("resp_cycle", 64'(cyc), 64'(got.at));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N  = 1'b0;
    IF_REQ   = 1'b0;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    M_READY  = 1'b0;
    M_RVALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, {63'd0, M_REQ}, 64'd0);
    chk({tag, "_m_we"}, {63'd0, M_WE}, 64'd0);
    chk({tag, "_m_size"}, {62'd0, M_SIZE}, 64'd0);
    chk({tag, "_m_addr"}, M_ADDR, 64'd0);
    chk({tag, "_m_wdata"}, M_WDATA, 64'd0);
    chk({tag, "_if_rvalid"}, {63'd0, IF_RVALID}, 64'd0);
    chk({tag, "_if_rdata"}, IF_RDATA, 64'd0);
    chk({tag, "_if_fault"}, {63'd0, IF_FAULT}, 64'd0);
    chk({tag, "_if_stall"}, {63'd0, IF_STALL}, 64'd0);
    chk({tag, "_mem_rvalid"}, {63'd0, MEM_RVALID}, 64'd0);
    chk({tag, "_mem_rdata"}, MEM_RDATA, 64'd0);
    chk({tag, "_mem_fault"}, {63'd0, MEM_FAULT}, 64'd0);
    chk({tag, "_mem_stall"}, {63'd0, MEM_STALL}, 64'd0);
  endtask

  // Downstream model: waits for M_REQ, checks the command, holds off M_READY for
  // rdy_dly cycles (checking stability), then accepts and answers the next cycle.
  task automatic serve(input logic [1:0] sz, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input int rdy_dly, input logic [63:0] rd);
    int n;
    n = 0;
    @(negedge CLK);
    while (!M_REQ && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("m_req_seen", {63'd0, M_REQ}, 64'd1);
    if (!M_REQ) return;
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) @(negedge CLK);
      chk("m_req_held", {63'd0, M_REQ}, 64'd1);
      chk("m_size", {62'd0, M_SIZE}, {62'd0, sz});
      chk("m_we", {63'd0, M_WE}, {63'd0, we});
      chk("m_addr", M_ADDR, addr);
      if (we) chk("m_wdata", M_WDATA, wd);
    end
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    chk("m_req_drop", {63'd0, M_REQ}, 64'd0);
    M_RVALID = 1'b1;
    M_RDATA  = rd;
    @(negedge CLK);
    M_RVALID = 1'b0;
    M_RDATA  = '0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  int c0;

  initial begin
    // reset state
    RESET_N = 1'b0;
    @(negedge CLK);
    chk_all_zero("reset");
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    // single MEM double-word load, minimum latency
    c0 = cyc;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_SIZE = 2'b11; MEM_ADDR = 64'h100;
    expect_resp(1'b1, 64'hDEADBEEF_00000001, 1'b0, c0 + 3);
    @(negedge CLK);
    chk("t1_stall_c0", {63'd0, MEM_STALL}, 64'd1);
    chk("t1_mreq_c0", {63'd0, M_REQ}, 64'd0);
    @(negedge CLK);
    chk("t1_mreq_c1", {63'd0, M_REQ}, 64'd1);
    chk("t1_msize_c1", {62'd0, M_SIZE}, 64'd3);
    chk("t1_maddr_c1", M_ADDR, 64'h100);
    chk("t1_stall_c1", {63'd0, MEM_STALL}, 64'd1);
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    chk("t1_mreq_c2", {63'd0, M_REQ}, 64'd0);
    chk("t1_stall_c2", {63'd0, MEM_STALL}, 64'd1);
    M_RVALID = 1'b1; M_RDATA = 64'hDEADBEEF_00000001;
    @(negedge CLK);
    M_RVALID = 1'b0; M_RDATA = '0;
    chk("t1_stall_c3", {63'd0, MEM_STALL}, 64'd0);
    chk("t1_if_stall", {63'd0, IF_STALL}, 64'd0);
    tick();
    MEM_REQ = 1'b0;
    repeat (2) tick();

    // IF and MEM both held high: MEM, IF, MEM
    do_reset();
    c0 = cyc;
    IF_REQ = 1'b1; IF_ADDR = 64'h1000;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_SIZE = 2'b11; MEM_ADDR = 64'h2008;
    expect_resp(1'b1, 64'h1111_2222_3333_4444, 1'b0, c0 + 3);
    expect_resp(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, c0 + 7);
    expect_resp(1'b1, 64'h0, 1'b0, c0 + 11);
    serve(2'b11, 1'b0, 64'h2008, 64'h0, 0, 64'h1111_2222_3333_4444);
    tick();
    MEM_WE = 1'b1; MEM_SIZE = 2'b01; MEM_ADDR = 64'h2002; MEM_WDATA = 64'hCAFE;
    serve(2'b10, 1'b0, 64'h1000, 64'h0, 0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    IF_REQ = 1'b0;
    serve(2'b01, 1'b1, 64'h2002, 64'hCAFE, 0, 64'h5555);
    chk("t2_if_rdata_kept", IF_RDATA, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    MEM_REQ = 1'b0; MEM_WE = 1'b0;
    repeat (2) tick();

    // misaligned store, then the tie goes to IF
    do_reset();
    c0 = cyc;
    MEM_REQ = 1'b1; MEM_WE = 1'b1; MEM_SIZE = 2'b10; MEM_ADDR = 64'h102; MEM_WDATA = 64'h77;
    expect_resp(1'b1, 64'h0, 1'b1, c0 + 1);
    @(negedge CLK);
    chk("t3_mreq_c0", {63'd0, M_REQ}, 64'd0);
    @(negedge CLK);
    chk("t3_mreq_c1", {63'd0, M_REQ}, 64'd0);
    chk("t3_stall_c1", {63'd0, MEM_STALL}, 64'd0);
    chk("t3_if_fault_untouched", {63'd0, IF_FAULT}, 64'd0);
    tick();
    c0 = cyc;
    IF_REQ = 1'b1; IF_ADDR = 64'h500;
    MEM_WE = 1'b0; MEM_SIZE = 2'b00; MEM_ADDR = 64'h103;
    expect_resp(1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, c0 + 3);
    expect_resp(1'b1, 64'h42, 1'b0, c0 + 7);
    serve(2'b10, 1'b0, 64'h500, 64'h0, 0, 64'h0123_4567_89AB_CDEF);
    tick();
    IF_REQ = 1'b0;
    serve(2'b00, 1'b0, 64'h103, 64'h0, 0, 64'h42);
    tick();
    MEM_REQ = 1'b0;
    repeat (2) tick();

    // backpressure: M_READY low for five ISSUE cycles
    do_reset();
    c0 = cyc;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_SIZE = 2'b10; MEM_ADDR = 64'h40;
    expect_resp(1'b1, 64'h9999, 1'b0, c0 + 8);
    serve(2'b10, 1'b0, 64'h40, 64'h0, 5, 64'h9999);
    tick();
    MEM_REQ = 1'b0;
    repeat (2) tick();

    // reset during WAIT, then a pending tie grants MEM first
    do_reset();
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_SIZE = 2'b11; MEM_ADDR = 64'h2000;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_mreq_c1", {63'd0, M_REQ}, 64'd1);
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    IF_REQ = 1'b1; IF_ADDR = 64'h600;
    #2 RESET_N = 1'b0;
    #1 chk_all_zero("t5_async");
    tick();
    RESET_N = 1'b1;
    c0 = cyc;
    expect_resp(1'b1, 64'hABCD, 1'b0, c0 + 3);
    expect_resp(1'b0, 64'hBCDE, 1'b0, c0 + 7);
    serve(2'b11, 1'b0, 64'h2000, 64'h0, 0, 64'hABCD);
    tick();
    MEM_REQ = 1'b0;
    serve(2'b10, 1'b0, 64'h600, 64'h0, 0, 64'hBCDE);
    tick();
    IF_REQ = 1'b0;
    repeat (2) tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // timeout from WAIT, late response swallowed, next grant normal
    do_reset();
    c0 = cyc;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_SIZE = 2'b10; MEM_ADDR = 64'h80;
    expect_resp(1'b1, 64'h0, 1'b1, c0 + 9);
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_mreq_c1", {63'd0, M_REQ}, 64'd1);
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    wait_until(c0 + 10);
    MEM_REQ = 1'b0;
    IF_REQ = 1'b1; IF_ADDR = 64'h3000;
    expect_resp(1'b0, 64'h77, 1'b0, c0 + 15);
    @(negedge CLK);
    chk("t6_stale_no_grant", {63'd0, M_REQ}, 64'd0);
    tick();
    M_RVALID = 1'b1; M_RDATA = 64'hBAD0_BAD0;
    @(negedge CLK);
    chk("t6_stale_no_grant2", {63'd0, M_REQ}, 64'd0);
    tick();
    M_RVALID = 1'b0; M_RDATA = '0;
    serve(2'b10, 1'b0, 64'h3000, 64'h0, 0, 64'h77);
    tick();
    IF_REQ = 1'b0;
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk("resp_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port. The fetch stage (IF) and the memory stage (MEM) share one downstream memory interface. The block sits between those stages and the memory file. It grants one access at a time, alternates between requesters under contention, checks alignment, and generates the per-requester stall and response signals.

## Interface
- `TIMEOUT_CYC`, default 64: cycles an access may spend in ISSUE+WAIT before abort (used only with the macro).
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `IF_REQ` in 1: fetch read request; held until `IF_RVALID`.
- `IF_ADDR` in 64: fetch address; size is fixed at word (`2'b10`).
- `IF_RDATA` out 64: fetch read data.
- `IF_RVALID` out 1: one-cycle response pulse.
- `IF_FAULT` out 1: qualifies `IF_RVALID`.
- `IF_STALL` out 1: `IF_REQ && !IF_RVALID`.
- `MEM_REQ` in 1: MEM-stage request; held until `MEM_RVALID`.
- `MEM_WE` in 1: store.
- `MEM_SIZE` in 2: 00 byte, 01 half, 10 word, 11 double.
- `MEM_ADDR` in 64, `MEM_WDATA` in 64: MEM-stage address and store data.
- `MEM_RDATA` out 64, `MEM_RVALID` out 1, `MEM_FAULT` out 1, `MEM_STALL` out 1: same rules as the IF set.
- `M_REQ` out 1, `M_WE` out 1, `M_SIZE` out 2, `M_ADDR` out 64, `M_WDATA` out 64: downstream command, registered.
- `M_READY` in 1: downstream accepts the command in a cycle where `M_REQ` is high.
- `M_RVALID` in 1, `M_RDATA` in 64: downstream response. Never asserted in the same cycle as acceptance.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no stale flag set, at least one request:
  - Pick the winner.
  - Latch the command fields and the owner.
  - Go to ISSUE, or to RESP with fault if the address is misaligned.
- Arbitration:
  - A lone requester wins.
  - If both request, the requester not granted last time wins.
  - After reset the last-grant pointer = IF, so MEM wins the first tie.
  - The pointer updates on every grant, including faulted grants.
- Alignment check:
  - half: `addr[0]`=0.
  - word: `addr[1:0]`=0.
  - double: `addr[2:0]`=0.
  - byte: always aligned.
  - A misaligned access never drives `M_REQ`. RESP follows with FAULT=1 and RDATA=0.
- ISSUE: `M_REQ`=1 with the latched fields. Stays until `M_READY`, then goes to WAIT (`M_REQ` drops).
- WAIT: on `M_RVALID`, latch `M_RDATA` into the owner's RDATA and go to RESP.
- RESP, exactly one cycle:
  - Owner's RVALID=1.
  - No arbitration takes place.
  - Then IDLE.
- Requester side: a requester drops its REQ in the cycle after RVALID, or changes the fields for a new access. REQ still high in IDLE is treated as a new request.
- RDATA and FAULT are held until the owner's next RVALID. The other requester's outputs are untouched.
- Stores return RDATA=0.

## Timing
- Reset values: all outputs 0, FSM=IDLE, pointer=IF, timeout counter=0, stale flag=0.
- Reset asserted mid-access aborts immediately and unconditionally; the downstream is not notified.
- Minimum latency: REQ sampled in IDLE at cycle 0, then:
  - cycle 1: ISSUE with `M_REQ`=1.
  - `M_READY` in cycle 1 gives WAIT in cycle 2.
  - `M_RVALID` in cycle 2 gives RESP, RVALID=1, in cycle 3.
- Misaligned access: RVALID in cycle 1.
- STALL is combinational from REQ and the registered RVALID. It is high from the REQ cycle through the cycle before RVALID.
- A request arriving while the other owner is in RESP is first considered in the following IDLE cycle.
- `M_RVALID` outside WAIT is ignored, except for stale-flag consumption (see Configuration).

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs during ISSUE and WAIT and clears on entry to ISSUE.
  - When it reaches `TIMEOUT_CYC`, the access aborts to RESP with FAULT=1, RDATA=0, and `M_REQ` dropped.
  - An abort from WAIT sets the stale flag. The next `M_RVALID` is discarded and clears the flag.
  - IDLE grants nothing while the stale flag is set.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter and no stale flag. Accesses wait indefinitely, and FAULT arises only from misalignment.

## Test plan
- Single MEM load:
  - Stimulus: `MEM_REQ`=1, size 11, addr 0x100, `M_READY` immediately, `M_RVALID` next cycle with 0xDEADBEEF_00000001.
  - Required: `MEM_RVALID` in cycle 3 with that data, FAULT=0, `MEM_STALL` high in cycles 0–2.
- Simultaneous IF and MEM requests held high for three accesses:
  - Required: grant order MEM, IF, MEM.
  - Required: the IF grant drives `M_SIZE`=10, `M_WE`=0.
- Misaligned store:
  - Stimulus: size 10 at addr 0x102.
  - Required: no `M_REQ`, `MEM_RVALID`+`MEM_FAULT` in cycle 1, pointer advanced.
- Backpressure:
  - Stimulus: `M_READY` low for 5 cycles.
  - Required: `M_REQ` and fields stable throughout; response arrives 1 cycle after the RESP-entry cycle.
- Reset mid-WAIT:
  - Stimulus: drop `RESET_N` asynchronously.
  - Required: all outputs 0 before the next edge, FSM=IDLE.
  - Required: after release, a pending IF+MEM tie grants MEM.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=8, no `M_RVALID`:
  - Required: FAULT response 8 cycles after ISSUE entry.
  - Required: a late `M_RVALID` is discarded, and the following grant then proceeds normally.
